// File: rtl/instr_assembler.sv
// Packs decoded MIPS fields (R/I/J) into 32-bit words and streams them into
// instruction memory at sequential word addresses, one word per cycle at best.
module instr_assembler #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic              last,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       adress,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_fmt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              last_seen_q, last_seen_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0] word;
  logic        legal, accept, wr_done;

  always_comb begin
    word = 32'd0;
    case (fmt)
      2'b00:   word = {opcode, rs, rt, rd, shamt, funct};
      2'b01:   word = {opcode, rs, rt, immediate};
      2'b10:   word = {opcode, adress};
      default: word = 32'd0;
    endcase
  end

  assign legal    = (fmt != 2'b11);
  // The output register may be refilled in the same cycle it drains.
  assign in_ready = (state_q == S_LOAD) && (!we_q || mem_ready) &&
                    (acc_q < DEPTH_C) && !last_seen_q;
  assign accept   = in_valid && in_ready;
  assign wr_done  = we_q && mem_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    count_d     = count_q;
    last_seen_d = last_seen_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;

    if (wr_done) we_d = 1'b0;
    if (wr_done && count_q != DEPTH_C) count_d = count_q + (ADDR_W+1)'(1);

    if (accept) begin
      if (last) last_seen_d = 1'b1;
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        ptr_d   = ptr_q + ADDR_W'(1);
        acc_d   = acc_q + (ADDR_W+1)'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_LOAD: begin
        // Decide on next-state values so done follows the final write directly.
        if ((last_seen_d || acc_d == DEPTH_C) && !we_d) state_d = S_DONE;
      end
      default: begin
        if (start) begin
          state_d     = S_LOAD;
          ptr_d       = BASE;
          acc_d       = '0;
          count_d     = '0;
          last_seen_d = 1'b0;
          err_d       = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= BASE;
      acc_q       <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= BASE;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign done      = (state_q == S_DONE);
  assign err_fmt   = err_q;

endmodule
